// File: rtl/tff_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tff_counter_pkg
//  Description : Mode encodings shared by the T-flop counter bank.
//  Revision    : 1.0  initial release
// ============================================================================
package tff_counter_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_MASK = 2'b11;

endpackage : tff_counter_pkg
`default_nettype wire

// File: rtl/tff_cell.sv
`default_nettype none
// ============================================================================
//  Module      : tff_cell
//  Description : One-bit T flip-flop with synchronous reset and enable.
//  Revision    : 1.0  initial release
// ============================================================================
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic T,
    output logic Q
);

    // Toggle on T when enabled; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            Q <= 1'b0;
        end else if (en) begin
            Q <= Q ^ T;
        end
    end

endmodule : tff_cell
`default_nettype wire

// File: rtl/tff_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tff_counter
//  Description : WIDTH-bit bank of T flip-flops acting as a modulo up/down
//                counter with saturating parallel load and a raw toggle-mask
//                mode. The top level only computes per-cell toggle inputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tff_counter
    import tff_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] t_mask,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    // Terminal value truncated to WIDTH bits; the modulus itself is kept one
    // bit wider so MODULUS == 2**WIDTH still compares correctly on load.
    localparam logic [WIDTH-1:0] C_TERM    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   C_MOD_EXT = (WIDTH+1)'(MODULUS);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] next_d;
    logic [WIDTH-1:0] w_toggle;
    logic [WIDTH-1:0] w_load_sat;
    logic             w_at_term;
    logic             w_at_zero;
    logic             wrap_d;
    logic             wrap_q;

    assign w_at_term  = (q_q == C_TERM);
    assign w_at_zero  = (q_q == '0);
    assign w_load_sat = ({1'b0, load_val} < C_MOD_EXT) ? load_val : C_TERM;

    // Next-state value and wrap pulse; load overrides the selected mode.
    always_comb begin
        next_d = q_q;
        wrap_d = 1'b0;
        if (load) begin
            next_d = w_load_sat;
        end else begin
            case (mode)
                MODE_HOLD: next_d = q_q;
                MODE_UP: begin
                    if (w_at_term) begin
                        next_d = '0;
                        wrap_d = 1'b1;
                    end else begin
                        next_d = q_q + WIDTH'(1);
                    end
                end
                MODE_DOWN: begin
                    if (w_at_zero) begin
                        next_d = C_TERM;
                        wrap_d = 1'b1;
                    end else begin
                        next_d = q_q - WIDTH'(1);
                    end
                end
                MODE_MASK: next_d = q_q ^ t_mask;
            endcase
        end
    end

    // Each cell flips exactly the bits that differ from the next value.
    assign w_toggle = q_q ^ next_d;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cells
            tff_cell u_cell (
                .clk   (clk),
                .reset (reset),
                .en    (en),
                .T     (w_toggle[i]),
                .Q     (q_q[i])
            );
        end
    endgenerate

    // Wrap pulse register; disabled cycles clear any pending pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_q <= 1'b0;
        end else if (!en) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;
    assign tc   = en & ~load & (((mode == MODE_UP)   & w_at_term) |
                                ((mode == MODE_DOWN) & w_at_zero));

endmodule : tff_counter
`default_nettype wire

// File: doc/tff_counter.md
Name: tff_counter

Overview:
- Parametrised successor to the single T flip-flop: a WIDTH-bit bank of T flip-flops with modulo up/down counting, parallel load and a raw per-bit toggle-mask mode.
- Serves as the team's generic counter/divider primitive for timers, clock-enable dividers and toggle registers in later labs.
- State is held only in WIDTH instances of a one-bit T-flop cell; the top level computes each cell's toggle input.

Parameters:
- WIDTH, 4, bit width of the count/toggle register (WIDTH >= 1).
- MODULUS, 16, count wraps modulo MODULUS in up/down modes; legal range 2 <= MODULUS <= 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock; all state updates on this edge only.
- reset  input  1  synchronous, active-high reset; highest priority.
- en  input  1  global enable; 0 = hold all state.
- mode  input  2  00 hold, 01 count up, 10 count down, 11 toggle-mask.
- load  input  1  synchronous parallel load request.
- load_val  input  WIDTH  value for load.
- t_mask  input  WIDTH  per-bit toggle request, used only in mode 11.
- q  output  WIDTH  registered count/toggle state.
- tc  output  1  combinational terminal-count flag.
- wrap  output  1  registered one-cycle pulse after a modulo wrap.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Port names are clk and reset. Reset does not act between edges.
- Reset value: q = 0 and wrap = 0 after any edge with reset = 1. tc follows from q.
- Priority at each rising edge of clk: reset > en = 0 > load > mode.
- en = 0: q holds and wrap <= 0. Reset still clears while en = 0.
- load = 1 (with en = 1), regardless of mode:
  - q <= load_val when load_val < MODULUS, otherwise q <= MODULUS-1 (saturating load).
  - wrap <= 0.
- Mode 00: q holds; wrap <= 0.
- Mode 01 (up):
  - q == MODULUS-1: q <= 0 and wrap <= 1.
  - otherwise: q <= q+1 and wrap <= 0.
- Mode 10 (down):
  - q == 0: q <= MODULUS-1 and wrap <= 1.
  - otherwise: q <= q-1 and wrap <= 0.
- Mode 11 (toggle-mask):
  - q <= q ^ t_mask, with no modulus check; a value >= MODULUS is legal here.
  - wrap <= 0.
  - If modes 01/10 are later entered with q >= MODULUS: up treats it as not terminal (q+1 using WIDTH-bit arithmetic, wrapping naturally at 2**WIDTH, with wrap = 0); down decrements normally.
- Latency:
  - q changes one edge after the inputs are sampled.
  - wrap is asserted in the cycle immediately following the wrapping edge, for exactly one cycle per wrap.
- tc = en & ~load & ((mode == 01 & q == MODULUS-1) | (mode == 10 & q == 0)). It is purely combinational with no register, so it predicts that the next edge wraps.
- Width rules:
  - All arithmetic is done at WIDTH bits; MODULUS-1 is truncated to WIDTH bits.
  - With MODULUS == 2**WIDTH the wrap is the natural overflow and the behaviour is identical.
- Implementation rules:
  - The next value is computed combinationally. Cell i gets T_i = q_i ^ next_i and en_i = 1 whenever the top-level en = 1.
  - No other flops exist besides the WIDTH cells and the wrap flop.
- Reset mid-operation: reset during counting or load clears q on that edge, with no partial update. The next non-reset edge counts from 0.

Decomposition:
- Package tff_counter_pkg:
  - localparams MODE_HOLD = 2'b00, MODE_UP = 2'b01, MODE_DOWN = 2'b10, MODE_MASK = 2'b11.
  - Nothing else is shared.
- Sub-module tff_cell: one-bit T flip-flop.
  - Ports: clk, reset (sync, active-high), en, T, Q.
  - Behaviour: Q <= 0 on reset, Q <= Q ^ T when en = 1, hold otherwise.
  - tff_counter instantiates WIDTH of them in a generate loop.

Test Plan (WIDTH=4, MODULUS=10 unless stated):
1. Reset with mode=01, en=1 → q=0, wrap=0. Count to q=7, assert reset for one edge → q=0. Next edge → q=1.
2. Up from 0 → after 9 edges q=9 with tc=1. 10th edge → q=0 and wrap=1 for exactly one cycle. Next edge → q=1, wrap=0.
3. Down from 0 with mode=10 → tc=1 before the edge. Edge → q=9, wrap=1. Next edge → q=8, wrap=0.
4. Load tests:
   - load=1, load_val=12 → q=9.
   - load=1, load_val=5, mode=01, with q=9 and tc forced to 0 by load → q=5, wrap=0.
5. Mask mode: mode=11, t_mask=4'b1010, q=4'b0011 → 4'b1001, then → 4'b0011, wrap stays 0. Then from q=4'b1111, mode=01 → q=0, wrap=0.
6. en=0 with mode=01, q=4 → q holds for 3 edges, tc=0, wrap=0. Assert reset while en=0 → q=0. With MODULUS=16, up at q=15 → q=0, wrap=1.
